// File: rtl/local_mem_burst_splitter_if.sv
// Avalon-MM bus bundle for local_mem_burst_splitter.
// The same interface type is used on both sides. Only BURST_W differs between
// the AFU-facing (slave) instance and the bank-facing (master) instance.
interface local_mem_burst_splitter_if #(
    parameter int unsigned ADDR_W  = 27,
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned BURST_W = 7
);
    logic [ADDR_W-1:0]   address;
    logic [BURST_W-1:0]  burstcount;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, burstcount, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, burstcount, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/local_mem_burst_splitter.sv
// Avalon-MM burst splitter: slave bursts of up to 2**(IN_BURST_W-1) lines are
// reissued as master sub-bursts of at most MAX_OUT = 2**(OUT_BURST_W-1) lines.
// Optional feature macro: LOCAL_MEM_BURST_ALIGN_EN. When it is defined, no
// sub-burst crosses a MAX_OUT-aligned address boundary.
module local_mem_burst_splitter #(
    parameter int unsigned ADDR_W      = 27,
    parameter int unsigned DATA_W      = 512,
    parameter int unsigned IN_BURST_W  = 7,
    parameter int unsigned OUT_BURST_W = 3
) (
    input logic                        clk,
    input logic                        reset_n,
    local_mem_burst_splitter_if.slave  avs,
    local_mem_burst_splitter_if.master avm
);
    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned MAX_OUT = 2 ** (OUT_BURST_W - 1);
    localparam logic [IN_BURST_W-1:0] MAX_OUT_W = IN_BURST_W'(MAX_OUT);
    localparam logic [IN_BURST_W-1:0] ONE_W     = IN_BURST_W'(1);

    typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

    state_e                state_q, state_d;
    logic                  ready_q;
    logic [ADDR_W-1:0]     cur_addr_q;
    logic [IN_BURST_W-1:0] remaining_q;
    logic [IN_BURST_W-1:0] in_left_q;   // slave write beats still to be taken
    logic [IN_BURST_W-1:0] beat_cnt_q;  // beats accepted within current sub-burst
    logic [DATA_W-1:0]     data_q;
    logic [BE_W-1:0]       be_q;
    logic                  valid_q;

    logic [IN_BURST_W-1:0] room;
    logic [IN_BURST_W-1:0] chunk;
    logic [IN_BURST_W-1:0] bc_in;
    logic                  rd_start, wr_start, rd_acc, wr_acc, wr_take;
    logic                  wr_stall, last_cmd, sub_done;

    // Sub-burst length and handshake qualifiers
    always_comb begin
`ifdef LOCAL_MEM_BURST_ALIGN_EN
        room = MAX_OUT_W - IN_BURST_W'(cur_addr_q[OUT_BURST_W-2:0]);
`else
        room = MAX_OUT_W;
`endif
        chunk    = (remaining_q < room) ? remaining_q : room;
        bc_in    = (avs.burstcount == '0) ? ONE_W : avs.burstcount;
        last_cmd = (remaining_q == chunk);
        rd_start = (state_q == StIdle) && ready_q && avs.read;
        wr_start = (state_q == StIdle) && ready_q && avs.write && !avs.read;
        rd_acc   = (state_q == StRd) && !avm.waitrequest;
        wr_acc   = (state_q == StWr) && valid_q && !avm.waitrequest;
        wr_stall = (valid_q && avm.waitrequest) || (in_left_q == '0);
        wr_take  = (state_q == StWr) && avs.write && !wr_stall;
        sub_done = wr_acc && ((beat_cnt_q + ONE_W) == chunk);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rd_start) begin
                    state_d = StRd;
                end else if (wr_start) begin
                    state_d = StWr;
                end
            end
            StRd: if (rd_acc && last_cmd) state_d = StIdle;
            StWr: if (sub_done && last_cmd) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus outputs; the read return path is a pure pass-through
    always_comb begin
        avs.waitrequest = 1'b1;
        avm.read        = 1'b0;
        avm.write       = 1'b0;
        avm.address     = cur_addr_q;
        avm.burstcount  = '0;
        unique case (state_q)
            StIdle: avs.waitrequest = !ready_q;
            StRd: begin
                avm.read       = 1'b1;
                avm.burstcount = OUT_BURST_W'(chunk);
            end
            StWr: begin
                avm.write       = valid_q;
                avm.burstcount  = OUT_BURST_W'(chunk);
                avs.waitrequest = wr_stall;
            end
            default: ;
        endcase
    end

    assign avm.writedata     = data_q;
    assign avm.byteenable    = be_q;
    assign avs.readdata      = avm.readdata;
    assign avs.readdatavalid = avm.readdatavalid;

    // Datapath: address/length tracking and the single-stage write register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b0;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            in_left_q   <= '0;
            beat_cnt_q  <= '0;
            data_q      <= '0;
            be_q        <= '0;
            valid_q     <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (rd_start || wr_start) begin
                cur_addr_q  <= avs.address;
                remaining_q <= bc_in;
                beat_cnt_q  <= '0;
            end
            if (wr_start) begin
                data_q    <= avs.writedata;
                be_q      <= avs.byteenable;
                valid_q   <= 1'b1;
                in_left_q <= bc_in - ONE_W;
            end
            if (rd_acc || sub_done) begin
                cur_addr_q  <= cur_addr_q + ADDR_W'(chunk);
                remaining_q <= remaining_q - chunk;
            end
            if (wr_take) begin
                data_q    <= avs.writedata;
                be_q      <= avs.byteenable;
                valid_q   <= 1'b1;
                in_left_q <= in_left_q - ONE_W;
            end else if (wr_acc) begin
                valid_q <= 1'b0;
            end
            if (wr_acc) begin
                beat_cnt_q <= sub_done ? '0 : beat_cnt_q + ONE_W;
            end
        end
    end
endmodule

// File: tb/tb_local_mem_burst_splitter.sv
// Self-checking bench for local_mem_burst_splitter (honours LOCAL_MEM_BURST_ALIGN_EN).
module tb_local_mem_burst_splitter;
    localparam int unsigned ADDR_W  = 27;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned IN_BW   = 7;
    localparam int unsigned OUT_BW  = 3;
    localparam int unsigned MAX_OUT = 4;

    logic clk = 1'b0;
    logic reset_n;
    bit   stall_mode;
    int   checks = 0;
    int   errors = 0;
    int   last_cycles;

    local_mem_burst_splitter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(IN_BW))  avs_bus ();
    local_mem_burst_splitter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(OUT_BW)) avm_bus ();

    local_mem_burst_splitter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IN_BURST_W(IN_BW), .OUT_BURST_W(OUT_BW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .avs    (avs_bus),
        .avm    (avm_bus)
    );

    always #5 clk = ~clk;

    // Bank back-pressure: random when stall_mode is set
    always @(posedge clk) begin
        #1;
        avm_bus.waitrequest = stall_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Observed bank-side traffic
    logic [ADDR_W-1:0] rd_addr[$];
    logic [OUT_BW-1:0] rd_bc[$];
    logic [ADDR_W-1:0] wb_addr[$];
    logic [OUT_BW-1:0] wb_bc[$];
    logic [DATA_W-1:0] wb_data[$];
    logic [7:0]        wb_be[$];

    always @(posedge clk) begin
        if (avm_bus.read === 1'b1 && avm_bus.waitrequest === 1'b0) begin
            rd_addr.push_back(avm_bus.address);
            rd_bc.push_back(avm_bus.burstcount);
        end
        if (avm_bus.write === 1'b1 && avm_bus.waitrequest === 1'b0) begin
            wb_addr.push_back(avm_bus.address);
            wb_bc.push_back(avm_bus.burstcount);
            wb_data.push_back(avm_bus.writedata);
            wb_be.push_back(avm_bus.byteenable);
        end
    end

    // Reference: expected sub-burst list from plain arithmetic
    int unsigned exp_addr[$];
    int unsigned exp_bc[$];

    task automatic build_exp(input int unsigned a_in, input int unsigned bc);
        int unsigned a = a_in % (1 << ADDR_W);
        int unsigned rem = (bc == 0) ? 1 : bc;
        int unsigned room, c;
        exp_addr.delete();
        exp_bc.delete();
        while (rem > 0) begin
            room = MAX_OUT;
`ifdef LOCAL_MEM_BURST_ALIGN_EN
            room = MAX_OUT - (a % MAX_OUT);
`endif
            c = (rem < room) ? rem : room;
            exp_addr.push_back(a);
            exp_bc.push_back(c);
            a = (a + c) % (1 << ADDR_W);
            rem -= c;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (avs_bus.waitrequest !== 1'b0 && n < 400) begin
            step();
            n++;
        end
        check({tag, "_ready_timeout"}, 64'(n < 400), 64'd1);
    endtask

    task automatic compare_rd(input string tag);
        check({tag, "_ncmd"}, 64'(rd_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < rd_addr.size(); i++) begin
            check({tag, "_addr"}, 64'(rd_addr[i]), 64'(exp_addr[i]));
            check({tag, "_bc"}, 64'(rd_bc[i]), 64'(exp_bc[i]));
        end
    endtask

    task automatic do_read(input int unsigned a, input int unsigned bc, input int exp_hi,
                           input bit chk_hi, input string tag);
        int unsigned nb = (bc == 0) ? 1 : bc;
        int hi = 0;
        int n = 0;
        logic [DATA_W-1:0] rd;
        rd_addr.delete();
        rd_bc.delete();
        wait_ready(tag);
        avs_bus.address    = ADDR_W'(a);
        avs_bus.burstcount = IN_BW'(bc);
        avs_bus.read       = 1'b1;
        step();
        avs_bus.read = 1'b0;
        while (avs_bus.waitrequest === 1'b1 && n < 400) begin
            hi++;
            step();
            n++;
        end
        check({tag, "_done_timeout"}, 64'(n < 400), 64'd1);
        if (chk_hi) check({tag, "_wait_cycles"}, 64'(hi), 64'(exp_hi));
        build_exp(a, bc);
        compare_rd(tag);
        for (int i = 0; i < int'(nb); i++) begin
            rd = {$urandom, $urandom};
            avm_bus.readdata      = rd;
            avm_bus.readdatavalid = 1'b1;
            #1;
            check({tag, "_rdata"}, 64'(avs_bus.readdata), 64'(rd));
            check({tag, "_rvalid"}, 64'(avs_bus.readdatavalid), 64'd1);
            step();
        end
        avm_bus.readdatavalid = 1'b0;
        #1;
        check({tag, "_rvalid_low"}, 64'(avs_bus.readdatavalid), 64'd0);
        #1;
    endtask

    task automatic do_write(input int unsigned a, input int unsigned bc, input string tag);
        int unsigned nb = (bc == 0) ? 1 : bc;
        int i = 0;
        int n = 0;
        int k = 0;
        bit acc;
        logic [DATA_W-1:0] d[$];
        logic [7:0] b[$];
        for (int j = 0; j < int'(nb); j++) begin
            d.push_back({$urandom, $urandom});
            b.push_back(8'($urandom));
        end
        wb_addr.delete();
        wb_bc.delete();
        wb_data.delete();
        wb_be.delete();
        wait_ready(tag);
        avs_bus.address    = ADDR_W'(a);
        avs_bus.burstcount = IN_BW'(bc);
        while (i < int'(nb) && n < 4000) begin
            avs_bus.write      = 1'b1;
            avs_bus.writedata  = d[i];
            avs_bus.byteenable = b[i];
            #1;
            acc = (avs_bus.waitrequest === 1'b0);
            step();
            if (acc) i++;
            n++;
        end
        avs_bus.write = 1'b0;
        last_cycles = n;
        check({tag, "_beats_taken"}, 64'(i), 64'(nb));
        wait_ready(tag);
        build_exp(a, bc);
        check({tag, "_nbeats"}, 64'(wb_addr.size()), 64'(nb));
        for (int c = 0; c < exp_addr.size(); c++) begin
            for (int j = 0; j < int'(exp_bc[c]); j++) begin
                if (k < wb_addr.size() && k < int'(nb)) begin
                    check({tag, "_addr"}, 64'(wb_addr[k]), 64'(exp_addr[c]));
                    check({tag, "_bc"}, 64'(wb_bc[k]), 64'(exp_bc[c]));
                    check({tag, "_data"}, 64'(wb_data[k]), 64'(d[k]));
                    check({tag, "_be"}, 64'(wb_be[k]), 64'(b[k]));
                end
                k++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        bit acc;
        int unsigned ra, rbc;
        logic [DATA_W-1:0] d6;
        reset_n               = 1'b0;
        stall_mode            = 1'b0;
        avs_bus.read          = 1'b0;
        avs_bus.write         = 1'b0;
        avs_bus.address       = '0;
        avs_bus.burstcount    = '0;
        avs_bus.writedata     = '0;
        avs_bus.byteenable    = '0;
        avm_bus.readdata      = '0;
        avm_bus.readdatavalid = 1'b0;
        #3;
        check("rst_avm_read", 64'(avm_bus.read), 64'd0);
        check("rst_avm_write", 64'(avm_bus.write), 64'd0);
        check("rst_avm_addr", 64'(avm_bus.address), 64'd0);
        check("rst_avm_bc", 64'(avm_bus.burstcount), 64'd0);
        check("rst_avm_wdata", 64'(avm_bus.writedata), 64'd0);
        check("rst_avs_wait", 64'(avs_bus.waitrequest), 64'd1);
        step();
        step();
        reset_n = 1'b1;
        #1;
        check("rel_wait_hi", 64'(avs_bus.waitrequest), 64'd1);
        step();
        check("rel_wait_lo", 64'(avs_bus.waitrequest), 64'd0);

        // Read 0x100 burst 10: three sub-reads, stalled for three cycles
        do_read(32'h100, 10, 3, 1'b1, "t1_read");

        // Write 0x20 burst 6, one beat per cycle
        do_write(32'h20, 6, "t2_write");
        check("t2_cycles", 64'(last_cycles), 64'd6);

        // 64-beat write under random back-pressure
        stall_mode = 1'b1;
        do_write(32'h300, 64, "t3_write");
        check("t3_ncmd", 64'(exp_addr.size()), 64'd16);
        stall_mode = 1'b0;

        // Unaligned read; expectation depends on the alignment build
        do_read(32'h103, 6, 0, 1'b0, "t4_read");

        // Random mix, including address wrap and burstcount 0
        for (int r = 0; r < 8; r++) begin
            stall_mode = 1'($urandom_range(0, 1));
            ra  = (r == 0) ? ((1 << ADDR_W) - 3) : $urandom_range(0, (1 << ADDR_W) - 1);
            rbc = (r == 1) ? 0 : $urandom_range(0, 64);
            if (r % 2 == 0) do_write(ra, rbc, "rnd_write");
            else            do_read(ra, rbc, 0, 1'b0, "rnd_read");
        end
        stall_mode = 1'b0;

        // Reset after the first sub-read of a 10-line burst
        rd_addr.delete();
        rd_bc.delete();
        wait_ready("t5");
        avs_bus.address    = ADDR_W'(32'h200);
        avs_bus.burstcount = IN_BW'(10);
        avs_bus.read       = 1'b1;
        step();
        avs_bus.read = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        check("t5_read_drop", 64'(avm_bus.read), 64'd0);
        check("t5_rst_wait", 64'(avs_bus.waitrequest), 64'd1);
        check("t5_rst_addr", 64'(avm_bus.address), 64'd0);
        check("t5_ncmd_before", 64'(rd_addr.size()), 64'd1);
        step();
        step();
        reset_n = 1'b1;
        #1;
        check("t5_rel_wait_hi", 64'(avs_bus.waitrequest), 64'd1);
        check("t5_no_read", 64'(avm_bus.read), 64'd0);
        step();
        check("t5_rel_wait_lo", 64'(avs_bus.waitrequest), 64'd0);
        do_read(32'h0, 1, 1, 1'b1, "t5_read0");

        // Read and write together: read first, write (burstcount 0) afterwards
        rd_addr.delete();
        rd_bc.delete();
        wb_addr.delete();
        wb_bc.delete();
        wb_data.delete();
        wb_be.delete();
        wait_ready("t6");
        d6 = {$urandom, $urandom};
        avs_bus.address    = ADDR_W'(32'h40);
        avs_bus.burstcount = '0;
        avs_bus.writedata  = d6;
        avs_bus.byteenable = 8'hA5;
        avs_bus.read       = 1'b1;
        avs_bus.write      = 1'b1;
        step();
        avs_bus.read = 1'b0;
        #1;
        check("t6_write_stalled", 64'(avs_bus.waitrequest), 64'd1);
        #1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 400) begin
            #1;
            acc = (avs_bus.waitrequest === 1'b0);
            step();
            n++;
        end
        avs_bus.write = 1'b0;
        check("t6_write_timeout", 64'(acc), 64'd1);
        wait_ready("t6_drain");
        build_exp(32'h40, 0);
        compare_rd("t6_read");
        check("t6_nbeats", 64'(wb_addr.size()), 64'd1);
        if (wb_addr.size() > 0) begin
            check("t6_waddr", 64'(wb_addr[0]), 64'h40);
            check("t6_wbc", 64'(wb_bc[0]), 64'd1);
            check("t6_wdata", 64'(wb_data[0]), 64'(d6));
            check("t6_wbe", 64'(wb_be[0]), 64'hA5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
